// File: rtl/data_mem_periph.sv
// MEM stage: word-addressed data RAM plus memory-mapped timer, LEDs, switches,
// 7-segment digit register and free-running tick counter.
module data_mem_periph #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irq
);
  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [2:0] SEL_TH   = 3'd0;
  localparam logic [2:0] SEL_TL   = 3'd1;
  localparam logic [2:0] SEL_TCON = 3'd2;
  localparam logic [2:0] SEL_LED  = 3'd3;
  localparam logic [2:0] SEL_SW   = 3'd4;
  localparam logic [2:0] SEL_DIGI = 3'd5;
  localparam logic [2:0] SEL_TICK = 3'd6;

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [7:0]  r_led;
  logic [11:0] r_digi;
  logic [31:0] r_systick;

  logic [AW-1:0] w_ram_idx;
  logic [2:0]    w_sel;
  logic          w_is_ram;
  logic          w_is_per;
  logic          w_wr_per;
  logic          w_tl_max;
  logic [31:0]   w_per_rd;

  assign w_ram_idx = Addr[AW+1:2];
  assign w_sel     = Addr[4:2];
  assign w_is_ram  = (Addr[31:AW+2] == '0);
  // Peripheral window is 0x40000000..0x4000001F; slot 7 is left unmapped.
  assign w_is_per  = (Addr[31:5] == 27'h2000000);
  assign w_wr_per  = MemWr && w_is_per;
  assign w_tl_max  = (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (MemWr && w_is_ram) begin
      r_ram[w_ram_idx] <= WriteData;
    end
  end

  // CPU writes take priority over the hardware timer update in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_tcon    <= '0;
      r_led     <= '0;
      r_digi    <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;

      if (w_wr_per && w_sel == SEL_TH) begin
        r_th <= WriteData;
      end

      if (w_wr_per && w_sel == SEL_TL) begin
        r_tl <= WriteData;
      end else if (r_tcon[0]) begin
        r_tl <= w_tl_max ? r_th : r_tl + 32'd1;
      end

      if (w_wr_per && w_sel == SEL_TCON) begin
        r_tcon <= WriteData[2:0];
      end else if (r_tcon[0] && r_tcon[1] && w_tl_max) begin
        r_tcon[2] <= 1'b1;
      end

      if (w_wr_per && w_sel == SEL_LED) begin
        r_led <= WriteData[7:0];
      end

      if (w_wr_per && w_sel == SEL_DIGI) begin
        r_digi <= WriteData[11:0];
      end
    end
  end

  always_comb begin
    w_per_rd = '0;
    case (w_sel)
      SEL_TH:   w_per_rd = r_th;
      SEL_TL:   w_per_rd = r_tl;
      SEL_TCON: w_per_rd = {29'd0, r_tcon};
      SEL_LED:  w_per_rd = {24'd0, r_led};
      SEL_SW:   w_per_rd = {24'd0, switch};
      SEL_DIGI: w_per_rd = {20'd0, r_digi};
      SEL_TICK: w_per_rd = r_systick;
      default:  w_per_rd = '0;
    endcase
  end

  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      if (w_is_ram) begin
        ReadData = r_ram[w_ram_idx];
      end else if (w_is_per) begin
        ReadData = w_per_rd;
      end
    end
  end

  assign led  = r_led;
  assign digi = r_digi;
  assign irq  = r_tcon[1] & r_tcon[2];
endmodule
